// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the write arbiter, registerFile and decode.
//   REG_W / DATA_W  : default register index and data widths
//   ZERO_REG        : hardwired-zero register index; writes to it are dropped
//   BANK_INT/FLOAT  : bank select encoding for the 'float' write-port bit
//   rr_wrap()       : modulo helper for the rotating arbiter search
package regfile_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STALL_W = 16;

  localparam logic [4:0] ZERO_REG   = 5'd0;
  localparam logic       BANK_INT   = 1'b0;
  localparam logic       BANK_FLOAT = 1'b1;

  function automatic int unsigned rr_wrap(int unsigned a, int unsigned n);
    return a % n;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus plus the shared register-file write port.
//   req_valid/req_ready : per-requester valid/ready handshake
//   req_reg/req_data    : packed per-requester index and data (requester i at [i*W +: W])
//   req_float           : per-requester bank select
//   writeReg/writeData/regWrite/float : registered write port into registerFile
// Modports: master = writeback sources / registerFile side, slave = the arbiter.
interface regfile_write_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned REG_W   = regfile_pkg::REG_W,
  parameter int unsigned DATA_W  = regfile_pkg::DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*REG_W-1:0]  req_reg;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_float;

  logic [REG_W-1:0]          writeReg;
  logic [DATA_W-1:0]         writeData;
  logic                      regWrite;
  logic                      float;

  modport master (
    output req_valid, req_reg, req_data, req_float,
    input  req_ready, writeReg, writeData, regWrite, float
  );

  modport slave (
    input  req_valid, req_reg, req_data, req_float,
    output req_ready, writeReg, writeData, regWrite, float
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational first-set search starting at a rotating pointer.
//   clk, reset : clock and synchronous active-high reset (pointer returns to 0)
//   en         : allow a grant this cycle
//   req        : candidate requests
//   gnt        : one-hot grant (zero when no grant)
//   gnt_valid  : a grant is issued this cycle
//   gnt_idx    : index of the granted requester
// The pointer moves to one past the winner, so a waiting requester sees at most
// NUM_REQ-1 other grants before its own.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IdxW-1:0]    gnt_idx
);

  logic [IdxW-1:0] ptr_q, ptr_d;

  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (en && !gnt_valid && req[rr_wrap(32'(ptr_q) + k, NUM_REQ)]) begin
        gnt[rr_wrap(32'(ptr_q) + k, NUM_REQ)] = 1'b1;
        gnt_valid = 1'b1;
        gnt_idx   = IdxW'(rr_wrap(32'(ptr_q) + k, NUM_REQ));
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) begin
      ptr_d = IdxW'(rr_wrap(32'(gnt_idx) + 1, NUM_REQ));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port among NUM_REQ writeback requesters.
//   clk   : system clock
//   reset : synchronous active-high reset
//   hold  : pipeline freeze, blocks every grant including zero-register sinks
//   bus   : slave side of regfile_write_arbiter_if (requests in, write port out)
//   stall_cnt : per-requester 16-bit saturating stall counters, present only when
//               REGFILE_ARB_STALL_CNT_EN is defined
// Requests to register 0 are accepted immediately and never written; the rest go
// through round-robin arbitration, and the winner is registered onto the write port.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned REG_W   = regfile_pkg::REG_W,
  parameter int unsigned DATA_W  = regfile_pkg::DATA_W
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  regfile_write_arbiter_if.slave bus
`ifdef REGFILE_ARB_STALL_CNT_EN
  ,
  output logic [NUM_REQ*STALL_W-1:0] stall_cnt
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] nonzero, cand, sink, gnt, req_ready;
  logic               gnt_valid, grant_en;
  logic [IdxW-1:0]    gnt_idx;

  logic [REG_W-1:0]   write_reg_q;
  logic [DATA_W-1:0]  write_data_q;
  logic               reg_write_q;
  logic               float_q;

  assign grant_en = !hold && !reset;

  always_comb begin
    nonzero = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      nonzero[i] = bus.req_reg[i*REG_W +: REG_W] != REG_W'(ZERO_REG);
    end
  end

  assign cand = bus.req_valid & nonzero;
  assign sink = bus.req_valid & ~nonzero;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .en        (grant_en),
    .req       (cand),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // gnt is already gated by grant_en; the sinks need the same gating here.
  assign req_ready     = grant_en ? (sink | gnt) : '0;
  assign bus.req_ready = req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      write_reg_q  <= '0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
      float_q      <= BANK_INT;
    end else if (gnt_valid) begin
      write_reg_q  <= bus.req_reg[gnt_idx*REG_W +: REG_W];
      write_data_q <= bus.req_data[gnt_idx*DATA_W +: DATA_W];
      reg_write_q  <= 1'b1;
      float_q      <= bus.req_float[gnt_idx];
    end else begin
      // Index, data and bank keep their last values; only the enable drops.
      reg_write_q  <= 1'b0;
    end
  end

  assign bus.writeReg  = write_reg_q;
  assign bus.writeData = write_data_q;
  assign bus.regWrite  = reg_write_q;
  assign bus.float     = float_q;

`ifdef REGFILE_ARB_STALL_CNT_EN
  logic [NUM_REQ-1:0][STALL_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (cand[i] && !req_ready[i] && stall_q[i] != '1) begin
          stall_q[i] <= stall_q[i] + 1'b1;
        end
      end
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int unsigned NR = 3;

  logic clk;
  logic reset;
  logic hold;

  int n_vec;
  int n_err;

  logic [31:0] rf_int [32];
  logic [31:0] rf_flt [32];

  regfile_write_arbiter_if #(.NUM_REQ(NR), .REG_W(5), .DATA_W(32)) bus ();

`ifdef REGFILE_ARB_STALL_CNT_EN
  logic [NR*16-1:0] stall_cnt;
`endif

  regfile_write_arbiter #(
    .NUM_REQ (NR),
    .REG_W   (5),
    .DATA_W  (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hold  (hold),
    .bus   (bus)
`ifdef REGFILE_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple registerFile model: commits the registered write on the following edge.
  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_int[i] = '0;
      rf_flt[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (bus.regWrite) begin
      if (bus.float) rf_flt[bus.writeReg] <= bus.writeData;
      else           rf_int[bus.writeReg] <= bus.writeData;
    end
  end

  // Requester obligation: a pending request stays valid and stable.
  logic [NR-1:0]    pend_q;
  logic [NR*5-1:0]  pend_reg;
  logic [NR*32-1:0] pend_data;
  logic [NR-1:0]    pend_flt;
  initial pend_q = '0;

  always @(posedge clk) begin
    for (int i = 0; i < int'(NR); i++) begin
      if (pend_q[i]) begin
        assert (bus.req_valid[i] && bus.req_reg[i*5 +: 5] == pend_reg[i*5 +: 5]
                && bus.req_data[i*32 +: 32] == pend_data[i*32 +: 32]
                && bus.req_float[i] == pend_flt[i])
          else $error("requester %0d dropped or changed a pending request", i);
      end
    end
    pend_q    = bus.req_valid & ~bus.req_ready;
    pend_reg  = bus.req_reg;
    pend_data = bus.req_data;
    pend_flt  = bus.req_float;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] r,
                         input logic [31:0] d, input logic f);
    bus.req_valid[i]         = v;
    bus.req_reg[i*5 +: 5]    = r;
    bus.req_data[i*32 +: 32] = d;
    bus.req_float[i]         = f;
  endtask

  // Check ready mid-cycle, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [NR-1:0] exp_rdy);
    @(negedge clk);
    check_eq({tag, ".ready"}, 64'(bus.req_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  logic [NR-1:0] rr_rdy [6];
  logic [4:0]    rr_reg [6];

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    hold  = 1'b0;
    bus.req_valid = '0;
    bus.req_reg   = '0;
    bus.req_data  = '0;
    bus.req_float = '0;

    // Reset holds ready low even with a valid request present.
    set_req(0, 1'b1, 5'd1, 32'd44, 1'b0);
    step("rst", 3'b000);
    check_eq("rst.regWrite", 64'(bus.regWrite), 64'd0);
    check_eq("rst.writeReg", 64'(bus.writeReg), 64'd0);
    check_eq("rst.writeData", 64'(bus.writeData), 64'd0);
    check_eq("rst.float", 64'(bus.float), 64'd0);
    reset = 1'b0;

    // Single request.
    step("single", 3'b001);
    check_eq("single.regWrite", 64'(bus.regWrite), 64'd1);
    check_eq("single.writeReg", 64'(bus.writeReg), 64'd1);
    check_eq("single.writeData", 64'(bus.writeData), 64'd44);
    check_eq("single.float", 64'(bus.float), 64'd0);
    set_req(0, 1'b0, 5'd0, 32'd0, 1'b0);
    step("idle1", 3'b000);
    check_eq("idle1.regWrite", 64'(bus.regWrite), 64'd0);
    check_eq("idle1.writeReg_held", 64'(bus.writeReg), 64'd1);
    check_eq("idle1.rf_int1", 64'(rf_int[1]), 64'd44);

    // Round-robin from a freshly reset pointer.
    reset = 1'b1;
    step("rr_rst", 3'b000);
    reset = 1'b0;
    set_req(0, 1'b1, 5'd1, 32'd44, 1'b0);
    set_req(1, 1'b1, 5'd2, 32'd20, 1'b0);
    set_req(2, 1'b1, 5'd3, 32'd30, 1'b0);
    rr_rdy = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rr_reg = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    for (int c = 0; c < 6; c++) begin
      step($sformatf("rr%0d", c), rr_rdy[c]);
      check_eq($sformatf("rr%0d.regWrite", c), 64'(bus.regWrite), 64'd1);
      check_eq($sformatf("rr%0d.writeReg", c), 64'(bus.writeReg), 64'(rr_reg[c]));
`ifdef REGFILE_ARB_STALL_CNT_EN
      if (c == 2) check_eq("rr.stall2", 64'(stall_cnt[2*16 +: 16]), 64'd2);
`endif
      // Each requester leaves once its second grant has gone through.
      if (c >= 3) set_req(c - 3, 1'b0, 5'd0, 32'd0, 1'b0);
    end

    // Zero-register sink alongside a real write.
    set_req(0, 1'b1, 5'd2, 32'd55, 1'b0);
    set_req(1, 1'b1, 5'd0, 32'hffff_ffff, 1'b0);
    step("zero", 3'b011);
    check_eq("zero.writeReg", 64'(bus.writeReg), 64'd2);
    check_eq("zero.writeData", 64'(bus.writeData), 64'd55);
    set_req(0, 1'b0, 5'd0, 32'd0, 1'b0);
    set_req(1, 1'b0, 5'd0, 32'd0, 1'b0);
    step("idle2", 3'b000);
    check_eq("zero.rf_int2", 64'(rf_int[2]), 64'd55);
    check_eq("zero.rf_int0", 64'(rf_int[0]), 64'd0);

    // Float bank select.
    set_req(2, 1'b1, 5'd1, 32'hf0f0_f0f0, 1'b1);
    step("bank", 3'b100);
    check_eq("bank.float", 64'(bus.float), 64'd1);
    check_eq("bank.writeReg", 64'(bus.writeReg), 64'd1);
    check_eq("bank.writeData", 64'(bus.writeData), 64'hf0f0_f0f0);
    set_req(2, 1'b0, 5'd0, 32'd0, 1'b0);
    step("idle3", 3'b000);
    check_eq("bank.rf_flt1", 64'(rf_flt[1]), 64'hf0f0_f0f0);
    check_eq("bank.rf_int1", 64'(rf_int[1]), 64'd44);

    // Hold blocks both arbitration and zero-register sinks.
    hold = 1'b1;
    set_req(0, 1'b1, 5'd31, 32'h3333_3333, 1'b0);
    set_req(1, 1'b1, 5'd0, 32'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step($sformatf("hold%0d", c), 3'b000);
      check_eq($sformatf("hold%0d.regWrite", c), 64'(bus.regWrite), 64'd0);
      check_eq($sformatf("hold%0d.writeReg", c), 64'(bus.writeReg), 64'd1);
    end
    hold = 1'b0;
    step("hold_rel", 3'b011);
    check_eq("hold_rel.regWrite", 64'(bus.regWrite), 64'd1);
    check_eq("hold_rel.writeReg", 64'(bus.writeReg), 64'd31);
    check_eq("hold_rel.writeData", 64'(bus.writeData), 64'h3333_3333);
    set_req(0, 1'b0, 5'd0, 32'd0, 1'b0);
    set_req(1, 1'b0, 5'd0, 32'd0, 1'b0);
    step("idle4", 3'b000);

    // Reset while req1 waits: pointer must return to 0 so req0 wins afterwards.
    set_req(0, 1'b1, 5'd7, 32'd99, 1'b0);
    step("pre", 3'b001);
    check_eq("pre.writeReg", 64'(bus.writeReg), 64'd7);
    set_req(0, 1'b0, 5'd0, 32'd0, 1'b0);
    set_req(1, 1'b1, 5'd5, 32'd77, 1'b0);
    reset = 1'b1;
    step("rstmid", 3'b000);
    check_eq("rstmid.regWrite", 64'(bus.regWrite), 64'd0);
    check_eq("rstmid.writeReg", 64'(bus.writeReg), 64'd0);
    reset = 1'b0;
    set_req(0, 1'b1, 5'd8, 32'd88, 1'b0);
    step("after0", 3'b001);
    check_eq("after0.writeReg", 64'(bus.writeReg), 64'd8);
    set_req(0, 1'b0, 5'd0, 32'd0, 1'b0);
    step("after1", 3'b010);
    check_eq("after1.writeReg", 64'(bus.writeReg), 64'd5);
    check_eq("after1.writeData", 64'(bus.writeData), 64'd77);
    set_req(1, 1'b0, 5'd0, 32'd0, 1'b0);
    step("idle5", 3'b000);
    check_eq("after.rf_int5", 64'(rf_int[5]), 64'd77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (writeReg, writeData, regWrite, float) among NUM_REQ writeback requesters, e.g. the integer ALU, the FPU and the load unit.
- Uses round-robin arbitration with a valid/ready handshake.
- Registers the granted write into the register-file write-port signals.
- Sits between the writeback sources and registerFile; it is the only driver of the write port.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- REG_W, 5, register index width.
- DATA_W, 32, write data width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- hold  input  1  pipeline freeze; no grants issued while high.
- req_valid  input  NUM_REQ  per-requester write request.
- req_ready  output  NUM_REQ  per-requester grant/accept (combinational).
- req_reg  input  NUM_REQ*REG_W  destination index; requester i at bits [i*REG_W +: REG_W].
- req_data  input  NUM_REQ*DATA_W  write data; requester i at bits [i*DATA_W +: DATA_W].
- req_float  input  NUM_REQ  bank select; 1 = float bank, 0 = integer bank.
- writeReg  output  REG_W  registered write index to registerFile.
- writeData  output  DATA_W  registered write data.
- regWrite  output  1  registered write enable.
- float  output  1  registered bank select.

Behaviour:
- Reset (clk edge with reset=1):
  - writeReg=0, writeData=0, regWrite=0, float=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is forced to 0 while reset is high.
- A transfer for requester i occurs on a clock edge where req_valid[i] and req_ready[i] are both 1.
- Requester obligation: while req_valid[i]=1 and req_ready[i]=0, req_reg, req_data and req_float must be held stable and valid must not drop. The bench asserts this.
- Zero-register sink:
  - Request with req_reg=0 (either bank) gets req_ready[i]=1 in the same cycle, unless hold or reset is high.
  - It does not take part in arbitration and produces no write.
  - Any number of zero-register requests may sink in one cycle.
- Arbitration:
  - Candidates are requesters with valid=1 and nonzero reg.
  - Grant goes to the first candidate searching i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - At most one nonzero grant per cycle.
  - When hold=1, no grant is issued.
- Latency:
  - The granted request appears on writeReg/writeData/float with regWrite=1 on the clock edge of the transfer (1-cycle registered).
  - registerFile commits it at the following edge.
- Idle or hold cycle: regWrite goes to 0 at the next edge. writeReg, writeData and float keep their previous values.
- Pointer update:
  - After a grant to requester g, rr_ptr = (g+1) mod NUM_REQ.
  - rr_ptr is unchanged when there is no grant.
  - Starvation bound: a valid requester waits at most NUM_REQ-1 grants.
- Same destination from two requesters in one cycle: only the round-robin winner is written this cycle. The loser writes in a later cycle, so the final value is whichever transferred last. No merging or ordering beyond round-robin.
- Reset mid-request: the pending request is not accepted. After reset deasserts, arbitration restarts at rr_ptr=0 and any write in the output register is discarded.
- A request with hold=1 and reset=1 together follows reset.

Optional Feature:
- Macro: REGFILE_ARB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, width NUM_REQ*16.
  - One saturating 16-bit counter per requester.
  - A counter increments on each cycle where req_valid[i]=1, req_reg nonzero and req_ready[i]=0 (hold cycles included).
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: the port and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package regfile_pkg:
  - REG_W, DATA_W, ZERO_REG = 5'd0.
  - Bank select constants BANK_INT=1'b0 and BANK_FLOAT=1'b1, also used by registerFile and decode.
- One sub-module: rr_arbiter, a NUM_REQ-wide combinational priority search from a rotating pointer, with the pointer register inside.
- The top level handles the zero-register sink, the hold/reset gating, and the output register.

Test Plan:
- Single request: req0 valid, reg=1, data=32'd44, float=0 -> ready0=1 same cycle; next edge regWrite=1, writeReg=1, writeData=44, float=0; registerFile int reg1 reads 44 afterwards.
- Round-robin: req0, req1, req2 all valid continuously, regs 1, 2, 3 -> grants 0, 1, 2, 0, 1 in consecutive cycles; regWrite held 1; with REGFILE_ARB_STALL_CNT_EN, stall_cnt for req2 = 2 after its first grant.
- Zero-register sink: req1 valid, reg=0, data=ffffffff, while req0 writes reg2 -> both ready in the same cycle; only reg2 written; int reg0 still reads 0.
- Bank select: req2 float=1, reg=1, data=f0f0f0f0 -> float=1, writeReg=1 on output; float reg1 = f0f0f0f0 and int reg1 unchanged at 44.
- Hold then release: hold=1 for 3 cycles with req0 valid, reg=31, data=33333333 -> ready0=0 and regWrite=0 throughout; the first cycle after hold=0 grants, then writeReg=31 with regWrite=1.
- Reset mid-operation: reset asserted for 1 cycle while req1 is waiting -> regWrite=0 and rr_ptr=0 after the edge; on release with req0 and req1 both valid, req0 is granted first.
